// File: rtl/hidden_layer_seq_if.sv
// Handshake/bus bundle for hidden_layer_seq: control, ROM/RAM ports, result.
// master = sequencer side, slave = control FSM / memories / activation store.
interface hidden_layer_seq_if #(
    parameter int ACC_W = 28
);
    logic                    start;
    logic [14:0]             w_addr;
    logic [7:0]              w_q;
    logic [9:0]              px_addr;
    logic [7:0]              px_q;
    logic                    out_valid;
    logic [4:0]              out_idx;
    logic signed [ACC_W-1:0] out_data;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, w_q, px_q,
        output w_addr, px_addr, out_valid, out_idx, out_data, busy, done
    );

    modport slave (
        output start, w_q, px_q,
        input  w_addr, px_addr, out_valid, out_idx, out_data, busy, done
    );
endinterface

// File: rtl/hidden_layer_seq.sv
// Hidden-layer dot-product sequencer: walks weight ROM and pixel RAM, MACs,
// emits one signed sum per neuron. Ports: clk, rst (sync, active-high),
// bus (master): start, w_addr/w_q, px_addr/px_q, out_valid/out_idx/out_data,
// busy, done. Optional macro HIDDEN_SEQ_RELU_EN clamps negative sums to 0.
module hidden_layer_seq #(
    parameter int NUM_INPUTS = 784,
    parameter int NUM_HIDDEN = 32,
    parameter int ACC_W      = 28
) (
    input  logic                clk,
    input  logic                rst,
    hidden_layer_seq_if.master  bus
);
    localparam logic [9:0] LAST_I = 10'(NUM_INPUTS - 1);
    localparam logic [4:0] LAST_N = 5'(NUM_HIDDEN - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, EMIT, FIN} state_t;

    state_t                  r_state;
    logic [4:0]              r_n;
    logic [9:0]              r_i;
    logic                    r_dv;
    logic signed [ACC_W-1:0] r_acc;
    logic [14:0]             r_waddr;
    logic [9:0]              r_paddr;
    logic                    r_ovalid;
    logic [4:0]              r_oidx;
    logic signed [ACC_W-1:0] r_odata;
    logic                    r_busy;
    logic                    r_done;

    logic signed [16:0]      w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;

    // Pixel is unsigned: zero-extend before the signed multiply.
    assign w_prod     = $signed(bus.w_q) * $signed({1'b0, bus.px_q});
    assign w_prod_ext = {{(ACC_W-17){w_prod[16]}}, w_prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_n      <= '0;
            r_i      <= '0;
            r_dv     <= 1'b0;
            r_acc    <= '0;
            r_waddr  <= '0;
            r_paddr  <= '0;
            r_ovalid <= 1'b0;
            r_oidx   <= '0;
            r_odata  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ovalid <= 1'b0;
            r_done   <= 1'b0;
            // Memory data lags the address by one cycle.
            r_dv     <= (r_state == ISSUE);
            if (r_dv)
                r_acc <= r_acc + w_prod_ext;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_n     <= '0;
                        r_i     <= '0;
                        r_waddr <= '0;
                        r_paddr <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Addresses hold on the last input so the weight
                    // counter never runs past the final ROM word.
                    if (r_i == LAST_I) begin
                        r_i     <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_i     <= r_i + 10'd1;
                        r_waddr <= r_waddr + 15'd1;
                        r_paddr <= r_paddr + 10'd1;
                    end
                end
                DRAIN: begin
                    r_state <= EMIT;
                end
                EMIT: begin
                    r_ovalid <= 1'b1;
                    r_oidx   <= r_n;
`ifdef HIDDEN_SEQ_RELU_EN
                    r_odata  <= r_acc[ACC_W-1] ? '0 : r_acc;
`else
                    r_odata  <= r_acc;
`endif
                    r_acc    <= '0;
                    if (r_n == LAST_N) begin
                        r_state <= FIN;
                    end else begin
                        r_n     <= r_n + 5'd1;
                        r_waddr <= r_waddr + 15'd1;
                        r_paddr <= '0;
                        r_state <= ISSUE;
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.w_addr    = r_waddr;
    assign bus.px_addr   = r_paddr;
    assign bus.out_valid = r_ovalid;
    assign bus.out_idx   = r_oidx;
    assign bus.out_data  = r_odata;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_hidden_layer_seq.sv
// Scoreboard bench for hidden_layer_seq: directed ROM/RAM images,
// expected results queued at start, popped by an out_valid monitor.
module tb_hidden_layer_seq;
    localparam int NI = 784;
    localparam int NH = 32;
    localparam int AW = 28;
`ifdef HIDDEN_SEQ_RELU_EN
    localparam longint EXP_B  = 0;
    localparam longint EXP_C1 = 0;
`else
    localparam longint EXP_B  = -199920;
    localparam longint EXP_C1 = -98040;
`endif
    localparam longint EXP_C0 = 196080;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hidden_layer_seq_if #(.ACC_W(AW)) bus();

    hidden_layer_seq #(
        .NUM_INPUTS(NI),
        .NUM_HIDDEN(NH),
        .ACC_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] rom [0:NI*NH-1];
    logic [7:0] ram [0:NI-1];

    always @(posedge clk) begin
        bus.w_q  <= rom[bus.w_addr];
        bus.px_q <= ram[bus.px_addr];
    end

    typedef struct {
        int     idx;
        longint data;
        int     off;
    } exp_t;

    exp_t sbq[$];
    int npass = 0;
    int ntot = 0;
    int cyc = 0;
    int t0 = 0;
    int exp_done = -1;
    int ndone = 0;
    int maxw = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (int'(bus.w_addr) > maxw) maxw = int'(bus.w_addr);
        if (bus.out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("out_idx", longint'(bus.out_idx), e.idx);
                chk("out_data", $signed(bus.out_data), e.data);
                chk("out_time", cyc - t0, e.off);
            end
        end
        if (bus.done) begin
            ndone++;
            chk("done_time", cyc - t0, exp_done);
        end
    end

    task automatic go();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_k(input int k);
        while (cyc - t0 < k) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_w_addr"}, longint'(bus.w_addr), 0);
        chk({tag, "_px_addr"}, longint'(bus.px_addr), 0);
        chk({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        chk({tag, "_out_idx"}, longint'(bus.out_idx), 0);
        chk({tag, "_out_data"}, longint'(bus.out_data), 0);
        chk({tag, "_busy"}, longint'(bus.busy), 0);
        chk({tag, "_done"}, longint'(bus.done), 0);
    endtask

    task automatic abort(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle(tag);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        for (int a = 0; a < NI*NH; a++) rom[a] = 8'h01;
        for (int a = 0; a < NI; a++) ram[a] = 8'h01;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        // Abort mid-ISSUE at cycle 300
        go();
        wait_k(300);
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort300");
        rst = 1'b0;

        // Full pass, all ones
        for (int n = 0; n < NH; n++)
            sbq.push_back('{n, 784, 786 * (n + 1)});
        exp_done = 25153;
        go();
        wait_k(1);
        chk("A_w_addr_k1", longint'(bus.w_addr), 1);
        chk("A_busy_k1", longint'(bus.busy), 1);
        wait_k(783);
        chk("A_w_addr_k783", longint'(bus.w_addr), 783);
        chk("A_px_addr_k783", longint'(bus.px_addr), 783);
        wait_k(784);
        chk("A_w_addr_drain", longint'(bus.w_addr), 783);
        wait_k(786);
        chk("A_w_addr_n1_first", longint'(bus.w_addr), 784);
        chk("A_px_addr_n1_first", longint'(bus.px_addr), 0);
        wait_k(1000);
        bus.start = 1'b1;
        wait_k(1001);
        bus.start = 1'b0;
        wait_k(1569);
        chk("A_w_addr_n1_last", longint'(bus.w_addr), 1567);
        chk("A_px_addr_n1_last", longint'(bus.px_addr), 783);
        wait_k(25140);
        bus.start = 1'b1;
        wait_k(25149);
        chk("A_w_addr_last", longint'(bus.w_addr), 25087);
        wait_k(25153);
        chk("A_done_fin", longint'(bus.done), 1);
        chk("A_busy_fin", longint'(bus.busy), 0);
        chk("A_w_addr_hold", longint'(bus.w_addr), 25087);
        chk("A_px_addr_hold", longint'(bus.px_addr), 783);
        wait_k(25154);
        bus.start = 1'b0;
        chk("A_restart_busy", longint'(bus.busy), 1);
        chk("A_restart_done", longint'(bus.done), 0);
        chk("A_restart_w_addr", longint'(bus.w_addr), 0);
        chk("A_done_count", ndone, 1);
        wait_k(25156);
        exp_done = -1;
        abort("abortA");
        chk("A_sb_empty", sbq.size(), 0);

        // All -1 weights, all 255 pixels
        for (int a = 0; a < NI*NH; a++) rom[a] = 8'hFF;
        for (int a = 0; a < NI; a++) ram[a] = 8'hFF;
        sbq.push_back('{0, EXP_B, 786});
        sbq.push_back('{1, EXP_B, 1572});
        go();
        wait_k(1600);
        abort("abortB");
        chk("B_sb_empty", sbq.size(), 0);

        // Neuron 0 weights +2, neuron 1 weights -1, pixels i%256
        for (int a = 0; a < NI*NH; a++)
            rom[a] = (a < NI) ? 8'h02 : ((a < 2*NI) ? 8'hFF : 8'h00);
        for (int a = 0; a < NI; a++) ram[a] = 8'(a % 256);
        sbq.push_back('{0, EXP_C0, 786});
        sbq.push_back('{1, EXP_C1, 1572});
        go();
        wait_k(1600);
        abort("abortC");
        chk("C_sb_empty", sbq.size(), 0);

        chk("max_w_addr", maxw, 25087);
        chk("total_done", ndone, 1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
